enc_feat_drain: RTL and testbench

//  Downstream drain stage of the hash-encoding lookup table. Takes row ids whose lookups are in flight
//  and polls the table until the row has all features returned. It then reads every column's
//  NUM_BANK-wide feature word out as a valid/ready stream toward the MLP, and frees (invalidates) the row.

---
 rtl/enc_feat_drain.sv | 223 ++++++++++++++++++++++
 tb/tb_enc_feat_drain.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/enc_feat_drain.sv
// enc_feat_drain: drain stage of the hash-encoding lookup table.
// Polls a pending row until all of its features are back, streams every
// column's NUM_BANK-wide feature word to the MLP, then frees the row.
module enc_feat_drain #(
  parameter int TABLE_ROW  = 32,
  parameter int TABLE_COL  = 128,
  parameter int NUM_BANK   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PEND_DEPTH = 4,
  parameter int OUT_DEPTH  = 4,
  parameter int READ_LAT   = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           req_valid,
  input  logic [DATA_WIDTH-1:0]          req_row,
  output logic                           req_ready,
  input  logic                           tbl_gnt,
  output logic                           tbl_req,
  output logic                           check_en,
  output logic                           feat_rd_en,
  output logic                           invalid_en,
  output logic [DATA_WIDTH-1:0]          target_row_id,
  output logic [DATA_WIDTH-1:0]          target_col_id,
  input  logic                           all_returned,
  input  logic [NUM_BANK*DATA_WIDTH-1:0] feat_rd_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_BANK*DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0]          out_row,
  output logic [DATA_WIDTH-1:0]          out_col,
  output logic                           out_last,
  output logic                           busy
);
  localparam int COLS = TABLE_COL / NUM_BANK;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int FW   = NUM_BANK * DATA_WIDTH;
  localparam int PPW  = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int PCW  = $clog2(PEND_DEPTH + 1);
  localparam int OPW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCW  = $clog2(OUT_DEPTH + 1);
  localparam int FLW  = $clog2(READ_LAT + 1);
  localparam int SW   = ((OCW > FLW) ? OCW : FLW) + 1;

  typedef enum logic [2:0] {IDLE, CHECK, READ, WAIT, FREE} state_t;

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] col;
    logic          last;
  } tag_t;

  typedef struct packed {
    logic [FW-1:0]         data;
    logic [DATA_WIDTH-1:0] row;
    logic [CW-1:0]         col;
    logic                  last;
  } beat_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] row_q, row_d;
  logic [CW-1:0]         col_q, col_d;

  logic [PEND_DEPTH-1:0][DATA_WIDTH-1:0] pend_mem_q, pend_mem_d;
  logic [PPW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [PCW-1:0] pend_cnt_q, pend_cnt_d;
  logic           pend_push, pend_pop;

  tag_t [READ_LAT-1:0] tag_q, tag_d;
  logic [FLW-1:0]      in_flight_q, in_flight_d;
  logic                ret, credit, wait_done;

  beat_t [OUT_DEPTH-1:0] omem_q, omem_d;
  logic [OPW-1:0] o_wr_q, o_wr_d, o_rd_q, o_rd_d;
  logic [OCW-1:0] o_cnt_q, o_cnt_d;
  logic           o_push, o_pop;

  function automatic logic [PPW-1:0] pinc(input logic [PPW-1:0] p);
    return (p == PPW'(PEND_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [OPW-1:0] oinc(input logic [OPW-1:0] p);
    return (p == OPW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_ready     = (pend_cnt_q != PCW'(PEND_DEPTH));
  assign busy          = (state_q != IDLE) || (pend_cnt_q != '0);
  assign target_row_id = row_q;
  assign target_col_id = DATA_WIDTH'(col_q);

  // A read may issue only if its word is guaranteed a slot in the output FIFO.
  assign ret       = tag_q[READ_LAT-1].vld;
  assign credit    = (SW'(in_flight_q) + SW'(o_cnt_q)) < SW'(OUT_DEPTH);
  // Nothing issues in WAIT, so the pipe is empty after this edge when the
  // only outstanding tag (if any) is the one returning now.
  assign wait_done = (in_flight_q == FLW'(ret));

  // Row-level FSM: next state and table commands.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    tbl_req    = 1'b0;
    check_en   = 1'b0;
    feat_rd_en = 1'b0;
    invalid_en = 1'b0;
    pend_pop   = 1'b0;
    unique case (state_q)
      IDLE: if (pend_cnt_q != '0) begin
        state_d = CHECK;
        row_d   = pend_mem_q[pend_rd_q];
      end
      CHECK: begin
        tbl_req = 1'b1;
        if (tbl_gnt) begin
          check_en = 1'b1;
          if (all_returned) begin
            state_d = READ;
            col_d   = '0;
          end
        end
      end
      READ: begin
        tbl_req = 1'b1;
        if (tbl_gnt && credit) begin
          feat_rd_en = 1'b1;
          col_d      = col_q + 1'b1;
          if (col_q == CW'(COLS - 1)) state_d = WAIT;
        end
      end
      WAIT: if (wait_done) state_d = FREE;
      FREE: begin
        tbl_req = 1'b1;
        if (tbl_gnt) begin
          invalid_en = 1'b1;
          pend_pop   = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending-row FIFO; head stays in place until the row is freed.
  always_comb begin
    pend_push  = req_valid && req_ready;
    pend_mem_d = pend_mem_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    if (pend_push) begin
      pend_mem_d[pend_wr_q] = req_row;
      pend_wr_d             = pinc(pend_wr_q);
    end
    if (pend_pop) pend_rd_d = pinc(pend_rd_q);
    pend_cnt_d = pend_cnt_q + PCW'(pend_push) - PCW'(pend_pop);
  end

  // Read-return tag shift, aligned with feat_rd_data READ_LAT cycles later.
  always_comb begin
    tag_d[0].vld  = feat_rd_en;
    tag_d[0].col  = col_q;
    tag_d[0].last = (col_q == CW'(COLS - 1));
    for (int i = 1; i < READ_LAT; i++) tag_d[i] = tag_q[i-1];
    in_flight_d = in_flight_q + FLW'(feat_rd_en) - FLW'(ret);
  end

  // Output FIFO, first-word-fall-through.
  assign o_push = ret;
  assign o_pop  = out_valid && out_ready;
  always_comb begin
    omem_d = omem_q;
    o_wr_d = o_wr_q;
    o_rd_d = o_rd_q;
    if (o_push) begin
      omem_d[o_wr_q].data = feat_rd_data;
      omem_d[o_wr_q].row  = row_q;
      omem_d[o_wr_q].col  = tag_q[READ_LAT-1].col;
      omem_d[o_wr_q].last = tag_q[READ_LAT-1].last;
      o_wr_d              = oinc(o_wr_q);
    end
    if (o_pop) o_rd_d = oinc(o_rd_q);
    o_cnt_d = o_cnt_q + OCW'(o_push) - OCW'(o_pop);
  end

  assign out_valid = (o_cnt_q != '0);
  assign out_data  = omem_q[o_rd_q].data;
  assign out_row   = omem_q[o_rd_q].row;
  assign out_col   = DATA_WIDTH'(omem_q[o_rd_q].col);
  assign out_last  = omem_q[o_rd_q].last;

  // State registers; reset aborts any row in progress without freeing it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      pend_mem_q  <= '0;
      pend_wr_q   <= '0;
      pend_rd_q   <= '0;
      pend_cnt_q  <= '0;
      tag_q       <= '0;
      in_flight_q <= '0;
      omem_q      <= '0;
      o_wr_q      <= '0;
      o_rd_q      <= '0;
      o_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pend_mem_q  <= pend_mem_d;
      pend_wr_q   <= pend_wr_d;
      pend_rd_q   <= pend_rd_d;
      pend_cnt_q  <= pend_cnt_d;
      tag_q       <= tag_d;
      in_flight_q <= in_flight_d;
      omem_q      <= omem_d;
      o_wr_q      <= o_wr_d;
      o_rd_q      <= o_rd_d;
      o_cnt_q     <= o_cnt_d;
    end
  end
endmodule

// File: tb/tb_enc_feat_drain.sv
// Bench for enc_feat_drain: table model + scoreboard; expected beats are
// queued when a row is accepted and popped by the monitor on each transfer.
`timescale 1ns/1ps
module tb_enc_feat_drain;
  localparam int TABLE_ROW = 32, TABLE_COL = 128, NUM_BANK = 8, DW = 32;
  localparam int PEND_DEPTH = 4, OUT_DEPTH = 4, RL = 2;
  localparam int COLS = TABLE_COL / NUM_BANK;
  localparam int FW = NUM_BANK * DW;

  logic clk = 1'b0;
  logic rstn;
  logic req_valid, req_ready, tbl_req, check_en, feat_rd_en, invalid_en;
  logic [DW-1:0] req_row, target_row_id, target_col_id, out_row, out_col;
  logic tbl_gnt = 1'b0, out_ready = 1'b0;
  logic all_returned, out_valid, out_last, busy;
  logic [FW-1:0] feat_rd_data, out_data;

  always #5 clk = ~clk;

  enc_feat_drain #(.TABLE_ROW(TABLE_ROW), .TABLE_COL(TABLE_COL), .NUM_BANK(NUM_BANK),
    .DATA_WIDTH(DW), .PEND_DEPTH(PEND_DEPTH), .OUT_DEPTH(OUT_DEPTH), .READ_LAT(RL)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_row(req_row), .req_ready(req_ready),
    .tbl_gnt(tbl_gnt), .tbl_req(tbl_req), .check_en(check_en), .feat_rd_en(feat_rd_en),
    .invalid_en(invalid_en), .target_row_id(target_row_id), .target_col_id(target_col_id),
    .all_returned(all_returned), .feat_rd_data(feat_rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy));

  int n_chk = 0, n_pass = 0;
  task automatic chk(input bit ok, input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Feature content the table model returns for (row, col).
  function automatic logic [FW-1:0] feat(input logic [DW-1:0] r, input int c);
    logic [FW-1:0] v;
    for (int b = 0; b < NUM_BANK; b++)
      v[b*DW +: DW] = (r * 32'h9E3779B1) ^ (DW'(c) << 8) ^ DW'(b) ^ 32'hC0DE0000;
    return v;
  endfunction

  typedef struct { logic [FW-1:0] data; logic [DW-1:0] row; int col; bit last; } exp_beat_t;
  exp_beat_t     exp_q[$];
  logic [DW-1:0] rows_q[$];
  int            fails_q[$], polls_q[$];
  int            h_checks = 0, h_col = 0, h_ok_cyc = 0, cyc = 0;
  bit            h_ret = 1'b0, tput_chk = 1'b0, held = 1'b0;
  int            issued = 0, popped = 0, req_fails = 0;
  int            gmode = 3, rmode = 3;
  logic [FW-1:0] dl [RL];
  logic [FW-1:0] hold_data;
  logic [DW-1:0] hold_row, hold_col;
  logic          hold_last;

  function automatic logic [FW-1:0] garbage();
    logic [FW-1:0] v;
    for (int b = 0; b < NUM_BANK; b++) v[b*DW +: DW] = $urandom;
    return v;
  endfunction

  // Grant / backpressure patterns: 0 always, 1 toggle, 2 random, 3 never.
  always @(negedge clk) begin
    case (gmode)
      0: tbl_gnt = 1'b1;
      1: tbl_gnt = ~tbl_gnt;
      2: tbl_gnt = ($urandom & 1) != 0;
      default: tbl_gnt = 1'b0;
    endcase
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = ($urandom & 1) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  // Table model and monitor: drive responses, then sample the settled cycle.
  always @(negedge clk) begin
    cyc++;
    feat_rd_data = dl[RL-1];
    for (int i = RL - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = garbage();
    all_returned = (fails_q.size() != 0) && (fails_q[0] == 0);
    #2;
    if (!rstn) begin
      exp_q.delete(); rows_q.delete(); fails_q.delete(); polls_q.delete();
      h_checks = 0; h_col = 0; h_ret = 0; issued = 0; popped = 0; held = 0;
      for (int i = 0; i < RL; i++) dl[i] = garbage();
    end else begin
      chk(req_ready == (rows_q.size() < PEND_DEPTH), "req_ready", req_ready, rows_q.size() < PEND_DEPTH);
      chk(busy == (rows_q.size() != 0), "busy", busy, rows_q.size() != 0);
      if (check_en || feat_rd_en || invalid_en) begin
        chk(tbl_req && tbl_gnt && ($countones({check_en, feat_rd_en, invalid_en}) == 1), "cmd_gnt_excl",
            {check_en, feat_rd_en, invalid_en, tbl_req, tbl_gnt}, 5'b00011);
        if (rows_q.size() == 0) chk(1'b0, "cmd_without_row", {check_en, feat_rd_en, invalid_en}, 0);
        else if (check_en) begin
          chk(target_row_id == rows_q[0] && !h_ret, "check_row", target_row_id, rows_q[0]);
          h_checks++;
          if (all_returned) begin h_ret = 1; h_ok_cyc = cyc; end
          else fails_q[0]--;
        end else if (feat_rd_en) begin
          chk(target_row_id == rows_q[0] && h_ret, "rd_row_returned", target_row_id, rows_q[0]);
          chk(target_col_id == h_col, "rd_col", target_col_id, h_col);
          chk(issued + 1 - popped <= OUT_DEPTH, "rd_credit", issued + 1 - popped, OUT_DEPTH);
          dl[0] = feat(target_row_id, int'(target_col_id));
          issued++; h_col++;
        end else begin
          chk(target_row_id == rows_q[0], "inv_row", target_row_id, rows_q[0]);
          chk(h_col == COLS, "inv_all_cols", h_col, COLS);
          chk(h_checks == polls_q[0] + 1, "inv_poll_count", h_checks, polls_q[0] + 1);
          if (tput_chk) chk(cyc - h_ok_cyc == COLS + RL + 1, "row_cycles", cyc - h_ok_cyc, COLS + RL + 1);
          void'(rows_q.pop_front()); void'(fails_q.pop_front()); void'(polls_q.pop_front());
          h_checks = 0; h_col = 0; h_ret = 0;
        end
      end
      if (held && out_valid)
        chk(out_data == hold_data && out_row == hold_row && out_col == hold_col && out_last == hold_last,
            "out_hold", {out_row, out_col, out_last}, {hold_row, hold_col, hold_last});
      held = out_valid && !out_ready;
      hold_data = out_data; hold_row = out_row; hold_col = out_col; hold_last = out_last;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "out_unexpected", {out_row, out_col}, 0);
        else begin
          exp_beat_t e;
          e = exp_q.pop_front();
          chk(out_row == e.row && out_col == e.col && out_last == e.last, "out_tag",
              {out_row, out_col, out_last}, {e.row, DW'(e.col), e.last});
          chk(out_data == e.data, "out_data", out_data, e.data);
        end
        popped++;
      end
      if (req_valid && req_ready) begin
        rows_q.push_back(req_row); fails_q.push_back(req_fails); polls_q.push_back(req_fails);
        for (int c = 0; c < COLS; c++) exp_q.push_back('{feat(req_row, c), req_row, c, c == COLS - 1});
      end
    end
  end

  // Offer one row; returns in the cycle whose closing edge accepts it.
  task automatic offer(input logic [DW-1:0] r, input int f);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_row = r; req_fails = f;
    #1;
    while (!req_ready && n < 2000) begin @(negedge clk); #1; n++; end
    if (n >= 2000) chk(1'b0, "offer_timeout", n, 2000);
  endtask

  task automatic idle_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); #3; n++; end
    while ((busy || exp_q.size() != 0 || rows_q.size() != 0) && n < budget);
    chk(n < budget, "drain_in_time", n, budget);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk(req_ready && !tbl_req && !check_en && !feat_rd_en && !invalid_en && !out_valid && !out_last && !busy,
        {nm, "_ctl"}, {req_ready, tbl_req, check_en, feat_rd_en, invalid_en, out_valid, out_last, busy}, 8'h80);
    chk(target_row_id == 0 && target_col_id == 0 && out_row == 0 && out_col == 0, {nm, "_ids"},
        {target_row_id, target_col_id, out_row, out_col}, 0);
    chk(out_data == 0, {nm, "_data"}, out_data, 0);
  endtask

  initial begin
    int n;
    req_valid = 0; req_row = 0; rstn = 1'b1;
    #1 rstn = 1'b0;
    #1 chk_reset_outs("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // single row, full rate
    gmode = 0; rmode = 0; tput_chk = 1;
    offer(5, 0); idle_req(); wait_idle(200);
    tput_chk = 0;

    // polling: three failed checks first
    offer(9, 3); idle_req(); wait_idle(200);

    // backpressure: only OUT_DEPTH reads may issue
    rmode = 3;
    offer(12, 0); idle_req();
    repeat (30) @(negedge clk);
    #3 chk(h_col == OUT_DEPTH, "bp_reads_issued", h_col, OUT_DEPTH);
    rmode = 0; wait_idle(200);

    // grant gaps
    gmode = 1;
    offer(20, 1); idle_req(); wait_idle(400);

    // queue fill without grant, then drain in order
    gmode = 3;
    offer(1, 0); offer(2, 0); offer(3, 0); offer(4, 1); idle_req();
    #1 chk(req_ready == 1'b0, "pend_full", req_ready, 0);
    gmode = 0; rmode = 2; wait_idle(800);

    // randomized traffic, ids beyond TABLE_ROW included
    gmode = 2; rmode = 2;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      offer(DW'($urandom_range(0, 63)), $urandom_range(0, 2));
      idle_req();
    end
    wait_idle(6000);

    // reset mid-READ right after column 7 issues
    gmode = 0; rmode = 0;
    offer(7, 0); idle_req();
    n = 0;
    do begin @(negedge clk); #3; n++; end while (h_col < 8 && n < 100);
    chk(n < 100, "reach_col7", n, 100);
    rstn = 1'b0;
    #1 chk_reset_outs("midrow_reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #3 chk(busy == 1'b0 && req_ready == 1'b1, "post_reset_idle", {busy, req_ready}, 2'b01);
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
